// File: rtl/mem_write_buffer_pkg.sv
// mem_write_buffer_pkg: shared widths, queue entry layout and drain state encoding
package mem_write_buffer_pkg;
  localparam int LINE_W = 7;
  localparam int BYTE_W = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = LINE_W + BYTE_W;
  localparam int MEM_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, GAPW = 2'd2} drain_t;
  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [BYTE_W-1:0] bsel;
    logic [DATA_W-1:0] data;
  } entry_t;
  function automatic logic [3:0] byte_en(input logic [BYTE_W-1:0] b);
    return 4'b0001 << b;
  endfunction
endpackage

// File: rtl/mem_write_buffer_if.sv
// mem_write_buffer_if: processor write, cache fetch and memory write bus of the write buffer
interface mem_write_buffer_if;
  import mem_write_buffer_pkg::*;
  logic wren, accept, rd_req, rd_hazard, mem_wren, full, empty;
  logic [ADDR_W-1:0] p_address;
  logic [DATA_W-1:0] p_data;
  logic [LINE_W-1:0] rd_line, mem_wr_line;
  logic [3:0] mem_byteena;
  logic [MEM_W-1:0] mem_wdata;
  modport master (
    output wren, p_address, p_data, rd_req, rd_line,
    input accept, rd_hazard, mem_wren, mem_wr_line, mem_byteena, mem_wdata, full, empty
  );
  modport slave (
    input wren, p_address, p_data, rd_req, rd_line,
    output accept, rd_hazard, mem_wren, mem_wr_line, mem_byteena, mem_wdata, full, empty
  );
endinterface

// File: rtl/mem_write_buffer_wb_fifo.sv
// wb_fifo: circular store of pending byte writes with tail overwrite and per-entry line/valid taps
module wb_fifo
  import mem_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input logic clock,
  input logic reset,
  input logic push,
  input logic pop,
  input logic ovr,
  input entry_t push_entry,
  input logic [DATA_W-1:0] ovr_data,
  output entry_t head_entry,
  output logic [ADDR_W-1:0] tail_key,
  output logic [PW:0] count,
  output logic full,
  output logic empty,
  output logic [DEPTH-1:0] valid,
  output logic [DEPTH-1:0][LINE_W-1:0] lines
);
  entry_t mem [DEPTH];
  logic [PW-1:0] head, tail, newest;
  assign newest = tail - PW'(1);
  assign head_entry = mem[head];
  assign tail_key = {mem[newest].line, mem[newest].bsel};
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= push_entry;
    if (ovr) mem[newest].data <= ovr_data;
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PW'(PW'(i) - head)} < count;
      lines[i] = mem[i].line;
    end
  end
endmodule

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: queues processor byte writes and drains them as byte-enabled memory line writes
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP = 1
) (
  input logic clock,
  input logic reset,
  mem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  drain_t state, next;
  logic [1:0] gcnt;
  entry_t head_e;
  logic [ADDR_W-1:0] tail_key;
  logic [PW:0] count;
  logic full, empty, coal, push, wr;
  logic [DEPTH-1:0] valid, hit;
  logic [DEPTH-1:0][LINE_W-1:0] lines;
  assign wr = state == WRITE;
  assign coal = bus.wren && !empty && tail_key == bus.p_address && !(wr && count == (PW+1)'(1));
  assign push = bus.wren && !full && !coal;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(wr),
    .ovr(coal),
    .push_entry({bus.p_address, bus.p_data}),
    .ovr_data(bus.p_data),
    .head_entry(head_e),
    .tail_key(tail_key),
    .count(count),
    .full(full),
    .empty(empty),
    .valid(valid),
    .lines(lines)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      gcnt <= '0;
    end else begin
      state <= next;
      gcnt <= state == GAPW ? gcnt + 2'd1 : 2'd0;
    end
  end
  always_comb begin
    next = state == WRITE ? (GAP > 0 ? GAPW : (count > (PW+1)'(1) ? WRITE : IDLE))
         : state == GAPW ? (gcnt == 2'(GAP - 1) ? (empty ? IDLE : WRITE) : GAPW)
         : (empty ? IDLE : WRITE);
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) hit[i] = valid[i] && lines[i] == bus.rd_line;
  end
  assign bus.rd_hazard = bus.rd_req && |hit;
  assign bus.accept = bus.wren && (coal || !full);
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.mem_wren = wr;
  assign bus.mem_wr_line = wr ? head_e.line : '0;
  assign bus.mem_byteena = wr ? byte_en(head_e.bsel) : '0;
  assign bus.mem_wdata = wr ? {4{head_e.data}} : '0;
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: table vectors, directed corner sequences and a randomized queue-model check
module tb_mem_write_buffer;
  import mem_write_buffer_pkg::*;
  localparam int DEPTH = 4;
  localparam int GAP = 1;
  logic clock = 0;
  logic reset = 1;
  always #5 clock = ~clock;
  mem_write_buffer_if bus();
  mem_write_buffer #(.DEPTH(DEPTH), .GAP(GAP)) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {logic [8:0] addr; logic [7:0] data; int elig;} ent_t;
  typedef struct {
    logic w; logic [8:0] a; logic [7:0] d; logic rq; logic [6:0] rl;
    logic acc, haz, mwr; logic [6:0] ml; logic [3:0] be; logic [31:0] wd; logic full, empty;
  } vec_t;
  ent_t q[$];
  vec_t tv[18];
  int n_cmp = 0, n_bad = 0, cyc = 0, next_ok = 0, rej = 0;
  bit checking = 0, found = 0;

  function automatic vec_t mk(input logic w, input logic [8:0] a, input logic [7:0] d, input logic rq,
                              input logic [6:0] rl, input logic acc, input logic haz, input logic mwr,
                              input logic [6:0] ml, input logic [3:0] be, input logic [31:0] wd,
                              input logic full, input logic empty);
    mk = '{w, a, d, rq, rl, acc, haz, mwr, ml, be, wd, full, empty};
  endfunction

  function automatic bit m_wr();
    return q.size() > 0 && q[0].elig <= cyc && cyc >= next_ok;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic acc, input logic haz, input logic mwr,
                            input logic [6:0] ml, input logic [3:0] be, input logic [31:0] wd,
                            input logic full, input logic empty);
    cmp({tag, ".accept"}, 32'(bus.accept), 32'(acc));
    cmp({tag, ".rd_hazard"}, 32'(bus.rd_hazard), 32'(haz));
    cmp({tag, ".mem_wren"}, 32'(bus.mem_wren), 32'(mwr));
    cmp({tag, ".mem_wr_line"}, 32'(bus.mem_wr_line), 32'(ml));
    cmp({tag, ".mem_byteena"}, 32'(bus.mem_byteena), 32'(be));
    cmp({tag, ".mem_wdata"}, bus.mem_wdata, wd);
    cmp({tag, ".full"}, 32'(bus.full), 32'(full));
    cmp({tag, ".empty"}, 32'(bus.empty), 32'(empty));
  endtask

  task automatic drive(input logic r, input logic w, input logic [8:0] a, input logic [7:0] d,
                       input logic rq, input logic [6:0] rl);
    @(posedge clock);
    #1;
    reset = r;
    bus.wren = w;
    bus.p_address = a;
    bus.p_data = d;
    bus.rd_req = rq;
    bus.rd_line = rl;
    @(negedge clock);
  endtask

  task automatic step(input logic r, input logic w, input logic [8:0] a, input logic [7:0] d,
                      input logic rq, input logic [6:0] rl);
    bit wr, coal, acc, haz;
    ent_t h;
    drive(r, w, a, d, rq, rl);
    wr = m_wr();
    coal = w && q.size() > 0 && q[q.size()-1].addr == a && !(wr && q.size() == 1);
    acc = w && (coal || q.size() < DEPTH);
    haz = 0;
    foreach (q[i]) if (rq && q[i].addr[8:2] == rl) haz = 1;
    h = wr ? q[0] : '{9'd0, 8'd0, 0};
    if (checking)
      check_outs($sformatf("model@%0d", cyc), acc, haz, wr, h.addr[8:2],
                 wr ? 4'b0001 << h.addr[1:0] : 4'b0000, {4{h.data}}, q.size() == DEPTH, q.size() == 0);
    if (r) begin
      q.delete();
      next_ok = 0;
    end else begin
      if (coal) q[q.size()-1].data = d;
      else if (acc) q.push_back('{a, d, cyc + 2});
      if (wr) begin
        void'(q.pop_front());
        next_ok = cyc + 1 + GAP;
      end
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.wren = 0;
    bus.p_address = 0;
    bus.p_data = 0;
    bus.rd_req = 0;
    bus.rd_line = 0;
    tv[0]  = mk(0, 9'h000, 8'h00, 0, 7'h00, 0, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[1]  = mk(1, 9'h1A6, 8'h5C, 0, 7'h00, 1, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[2]  = mk(0, 9'h000, 8'h00, 0, 7'h00, 0, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 0);
    tv[3]  = mk(0, 9'h000, 8'h00, 0, 7'h00, 0, 0, 1, 7'h69, 4'b0100, 32'h5C5C5C5C, 0, 0);
    tv[4]  = mk(0, 9'h000, 8'h00, 0, 7'h00, 0, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[5]  = mk(0, 9'h000, 8'h00, 0, 7'h00, 0, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[6]  = mk(1, 9'h014, 8'hAA, 1, 7'h05, 1, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[7]  = mk(0, 9'h000, 8'h00, 1, 7'h05, 0, 1, 0, 7'h00, 4'b0000, 32'h0, 0, 0);
    tv[8]  = mk(0, 9'h000, 8'h00, 1, 7'h05, 0, 1, 1, 7'h05, 4'b0001, 32'hAAAAAAAA, 0, 0);
    tv[9]  = mk(0, 9'h000, 8'h00, 1, 7'h05, 0, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[10] = mk(0, 9'h000, 8'h00, 1, 7'h06, 0, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[11] = mk(1, 9'h080, 8'h01, 0, 7'h00, 1, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[12] = mk(1, 9'h010, 8'h11, 1, 7'h06, 1, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 0);
    tv[13] = mk(1, 9'h010, 8'h22, 1, 7'h04, 1, 1, 1, 7'h20, 4'b0001, 32'h01010101, 0, 0);
    tv[14] = mk(0, 9'h000, 8'h00, 1, 7'h04, 0, 1, 0, 7'h00, 4'b0000, 32'h0, 0, 0);
    tv[15] = mk(0, 9'h000, 8'h00, 1, 7'h04, 0, 1, 1, 7'h04, 4'b0001, 32'h22222222, 0, 0);
    tv[16] = mk(0, 9'h000, 8'h00, 1, 7'h04, 0, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    tv[17] = mk(0, 9'h000, 8'h00, 0, 7'h00, 0, 0, 0, 7'h00, 4'b0000, 32'h0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    foreach (tv[i]) begin
      drive(0, tv[i].w, tv[i].a, tv[i].d, tv[i].rq, tv[i].rl);
      check_outs($sformatf("vec%0d", i), tv[i].acc, tv[i].haz, tv[i].mwr, tv[i].ml, tv[i].be,
                 tv[i].wd, tv[i].full, tv[i].empty);
    end
    checking = 1;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 9'(9'h100 + 4 * i), 8'(i + 1), 0, 0);
      rej += int'(!bus.accept);
    end
    cmp("fill_rejects", 32'(rej), 32'd1);
    repeat (12) step(0, 0, 0, 0, 0, 0);
    cmp("drained_empty", 32'(bus.empty), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 9'(9'h040 + 5 * i), 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 10 && !found; i++)
      if (m_wr() && q.size() == 3) found = 1;
      else step(0, 0, 0, 0, 0, 0);
    cmp("rst_in_write_reached", 32'(found), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    cmp("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    cmp("rst_empty", 32'(bus.empty), 32'd1);
    repeat (8) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 255) == 0, $urandom_range(0, 9) < 6, 9'($urandom_range(0, 15)),
           8'($urandom), $urandom_range(0, 1) == 1, 7'($urandom_range(0, 4)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
